i2c_task_scheduler: RTL and testbench

Central sequencer for the DHT/I2C project loop. It replaces pulse-driven step selection with an explicit FSM and runs the cycle: measure (DHT) -> store -> LCD update -> WS2812 refresh. It issues one-cycle start pulses to each task block, waits for each done pulse under a watchdog timeout, and publishes the current step code. The step code is consumed by the I2C LCD and data-store blocks.

---
 rtl/i2c_proj_pkg.sv | 42 ++++
 rtl/i2c_task_scheduler_if.sv | 41 ++++
 rtl/sched_timebase.sv | 65 ++++++
 rtl/i2c_task_scheduler.sv | 154 +++++++++++++++
 tb/tb_i2c_task_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_proj_pkg.sv
// Shared types and step codes for the project-loop sequencer.
// State codes, published step codes and the step mapping helper.
package i2c_proj_pkg;

    localparam int STEP_W_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_DHT   = 3'd1;
    localparam state_t S_STORE = 3'd2;
    localparam state_t S_LCD   = 3'd3;
    localparam state_t S_WS    = 3'd4;
    localparam state_t S_ERR   = 3'd5;

    localparam logic [7:0] STEP_IDLE   = 8'h00;
    localparam logic [7:0] STEP_WS2812 = 8'h01;
    localparam logic [7:0] STEP_DHT    = 8'h02;
    localparam logic [7:0] STEP_STORE  = 8'h03;
    localparam logic [7:0] STEP_LCD    = 8'h04;
    localparam logic [7:0] STEP_ERR    = 8'hFF;

    function automatic logic [7:0] step_of(state_t s);
        logic [7:0] v;
        v = STEP_IDLE;
        case (s)
            S_DHT:   v = STEP_DHT;
            S_STORE: v = STEP_STORE;
            S_LCD:   v = STEP_LCD;
            S_WS:    v = STEP_WS2812;
            S_ERR:   v = STEP_ERR;
            default: v = STEP_IDLE;
        endcase
        return v;
    endfunction

    function automatic logic is_wait(state_t s);
        return (s == S_DHT) || (s == S_STORE) ||
               (s == S_LCD) || (s == S_WS);
    endfunction

endpackage

// File: rtl/i2c_task_scheduler_if.sv
// Start/done handshake bundle between the sequencer and its task blocks.
// master = sequencer side, slave = task blocks / status consumers.
interface i2c_task_scheduler_if
    import i2c_proj_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF
);
    logic              button_req;
    logic              dht_done;
    logic              dht_err;
    logic              store_done;
    logic              lcd_done;
    logic              ws2812_done;
    logic              dht_start;
    logic              store_start;
    logic              lcd_start;
    logic              ws2812_start;
    logic [STEP_W-1:0] project_step;
    logic              busy;
    logic              timeout_flag;
    logic [3:0]        LEDR;

    modport master (
        input  button_req, dht_done, dht_err,
        input  store_done, lcd_done, ws2812_done,
        output dht_start, store_start,
        output lcd_start, ws2812_start,
        output project_step, busy,
        output timeout_flag, LEDR
    );

    modport slave (
        output button_req, dht_done, dht_err,
        output store_done, lcd_done, ws2812_done,
        input  dht_start, store_start,
        input  lcd_start, ws2812_start,
        input  project_step, busy,
        input  timeout_flag, LEDR
    );

endinterface

// File: rtl/sched_timebase.sv
// Timebase for the sequencer: 1 ms prescaler, period counter, watchdog.
// o_expire is a level meaning "the period ends on the next ms tick".
module sched_timebase
    import i2c_proj_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int PERIOD_MS      = 2000,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_reload,
    input  logic i_wd_clr,
    input  logic i_wd_run,
    output logic o_ms_tick,
    output logic o_expire,
    output logic o_timeout
);

    localparam int DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;

    logic [31:0] r_pre;
    logic [31:0] r_per;
    logic [31:0] r_wd;
    logic        w_tick;
    logic        w_last;

    assign w_tick    = (r_pre == 32'(DIV - 1));
    assign w_last    = (r_per == 32'd1);
    assign o_ms_tick = w_tick;
    assign o_expire  = w_last;
    assign o_timeout = i_wd_run &&
                       (r_wd == 32'(TIMEOUT_CYCLES - 1));

    // free-running ms prescaler
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_pre <= '0;
        else if (w_tick)
            r_pre <= '0;
        else
            r_pre <= r_pre + 32'd1;
    end

    // period down-counter; reloads itself on expiry so it never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_per <= 32'(PERIOD_MS);
        else if (i_reload || (w_tick && w_last))
            r_per <= 32'(PERIOD_MS);
        else if (w_tick)
            r_per <= r_per - 32'd1;
    end

    // watchdog: counts cycles spent in a wait state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_wd <= '0;
        else if (i_wd_clr)
            r_wd <= '0;
        else if (i_wd_run)
            r_wd <= r_wd + 32'd1;
    end

endmodule

// File: rtl/i2c_task_scheduler.sv
// Project-loop sequencer: DHT -> store -> LCD -> WS2812 with watchdog.
// Starts are registered one-cycle pulses issued on state entry.
module i2c_task_scheduler
    import i2c_proj_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int PERIOD_MS      = 2000,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int STEP_W         = STEP_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    i2c_task_scheduler_if.master   bus
);

    state_t            r_state;
    state_t            w_nxt;
    logic [STEP_W-1:0] r_step;
    logic              r_busy;
    logic              r_pend;
    logic              r_tflag;
    logic              r_dht_err;
    logic              r_toggle;
    logic              r_dht_start;
    logic              r_store_start;
    logic              r_lcd_start;
    logic              r_ws_start;

    logic              w_ms_tick;
    logic              w_expire;
    logic              w_timeout;
    logic              w_due;
    logic              w_wait;
    logic              w_trig;
    logic              w_chg;
    logic              w_reload;
    logic              w_enter_err;

    sched_timebase #(
        .CLK_HZ         (CLK_HZ),
        .PERIOD_MS      (PERIOD_MS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tb (
        .clk       (clk),
        .rst       (rst),
        .i_reload  (w_reload),
        .i_wd_clr  (w_chg),
        .i_wd_run  (w_wait),
        .o_ms_tick (w_ms_tick),
        .o_expire  (w_expire),
        .o_timeout (w_timeout)
    );

    assign w_due       = w_ms_tick & w_expire;
    assign w_wait      = is_wait(r_state);
    assign w_trig      = w_due | bus.button_req | r_pend;
    assign w_chg       = (w_nxt != r_state);
    assign w_reload    = (r_state == S_IDLE) && w_trig;
    assign w_enter_err = (w_nxt == S_ERR) && (r_state != S_ERR);

    // next state: expected done beats a same-cycle timeout
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:
                if (w_trig)
                    w_nxt = S_DHT;
            S_DHT:
                if (bus.dht_done)
                    w_nxt = bus.dht_err ? S_LCD : S_STORE;
                else if (w_timeout)
                    w_nxt = S_ERR;
            S_STORE:
                if (bus.store_done)
                    w_nxt = S_LCD;
                else if (w_timeout)
                    w_nxt = S_ERR;
            S_LCD:
                if (bus.lcd_done)
                    w_nxt = S_WS;
                else if (w_timeout)
                    w_nxt = S_ERR;
            S_WS:
                if (bus.ws2812_done)
                    w_nxt = S_IDLE;
                else if (w_timeout)
                    w_nxt = S_ERR;
            S_ERR:
                if (bus.button_req)
                    w_nxt = S_IDLE;
            default:
                w_nxt = S_IDLE;
        endcase
    end

    // state, step code, busy and entry start pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_step        <= '0;
            r_busy        <= 1'b0;
            r_dht_start   <= 1'b0;
            r_store_start <= 1'b0;
            r_lcd_start   <= 1'b0;
            r_ws_start    <= 1'b0;
        end else begin
            r_state       <= w_nxt;
            r_step        <= STEP_W'(step_of(w_nxt));
            r_busy        <= is_wait(w_nxt);
            r_dht_start   <= w_chg && (w_nxt == S_DHT);
            r_store_start <= w_chg && (w_nxt == S_STORE);
            r_lcd_start   <= w_chg && (w_nxt == S_LCD);
            r_ws_start    <= w_chg && (w_nxt == S_WS);
        end
    end

    // status flags: DHT error, completion toggle, sticky timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dht_err <= 1'b0;
            r_toggle  <= 1'b0;
            r_tflag   <= 1'b0;
        end else begin
            if ((r_state == S_DHT) && bus.dht_done)
                r_dht_err <= bus.dht_err;
            if ((r_state == S_WS) && bus.ws2812_done)
                r_toggle <= ~r_toggle;
            if (w_enter_err)
                r_tflag <= 1'b1;
            else if ((r_state == S_ERR) && bus.button_req)
                r_tflag <= 1'b0;
        end
    end

    // 1-deep request queue; an aborted cycle drops what was queued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_pend <= 1'b0;
        else if (w_enter_err || w_reload)
            r_pend <= 1'b0;
        else if (w_wait && (bus.button_req || w_due))
            r_pend <= 1'b1;
    end

    assign bus.dht_start    = r_dht_start;
    assign bus.store_start  = r_store_start;
    assign bus.lcd_start    = r_lcd_start;
    assign bus.ws2812_start = r_ws_start;
    assign bus.project_step = r_step;
    assign bus.busy         = r_busy;
    assign bus.timeout_flag = r_tflag;
    assign bus.LEDR         = {r_tflag, r_toggle, r_dht_err, r_busy};

endmodule

// File: tb/tb_i2c_task_scheduler.sv
// Bench for i2c_task_scheduler: directed scenarios plus random traffic.
// Reference model works on absolute cycle numbers and phase codes.
module tb_i2c_task_scheduler;

    localparam int PERIOD  = 20;
    localparam int TIMEOUT = 50;

    logic clk;
    logic rst;

    i2c_task_scheduler_if #(.STEP_W(8)) bus ();

    i2c_task_scheduler #(
        .CLK_HZ         (1000),
        .PERIOD_MS      (PERIOD),
        .TIMEOUT_CYCLES (TIMEOUT),
        .STEP_W         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int cyc;

    int m_phase;
    int m_enter;
    int m_reload;
    bit m_pend;
    bit m_dhterr;
    bit m_toggle;
    bit m_tflag;
    logic [3:0] m_starts;

    bit auto_resp;
    bit rand_mode;
    int fixed_delay;
    int err_mode;
    logic [3:0] suppress;
    int rd;
    int rtask;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit ph_busy(int p);
        return (p == 1) || (p == 2) || (p == 3) || (p == 4);
    endfunction

    task automatic model_reset();
        cyc      = 0;
        m_phase  = 0;
        m_enter  = 0;
        m_reload = 0;
        m_pend   = 0;
        m_dhterr = 0;
        m_toggle = 0;
        m_tflag  = 0;
        m_starts = '0;
        rd       = 0;
    endtask

    task automatic model_step();
        bit expire, tmo, bz, req;
        int nxt;
        cyc++;
        req    = bus.button_req;
        expire = (cyc - m_reload) == PERIOD;
        if (expire) m_reload = cyc;
        bz  = ph_busy(m_phase);
        tmo = bz && ((cyc - m_enter) == TIMEOUT);
        nxt = m_phase;
        m_starts = '0;
        if (bz && (req || expire)) m_pend = 1;
        case (m_phase)
            0: if (expire || req || m_pend) begin
                nxt = 2; m_pend = 0; m_reload = cyc;
            end
            2: if (bus.dht_done) begin
                m_dhterr = bus.dht_err;
                nxt = bus.dht_err ? 4 : 3;
            end else if (tmo) nxt = 255;
            3: if (bus.store_done) nxt = 4;
               else if (tmo) nxt = 255;
            4: if (bus.lcd_done) nxt = 1;
               else if (tmo) nxt = 255;
            1: if (bus.ws2812_done) begin
                nxt = 0; m_toggle = ~m_toggle;
            end else if (tmo) nxt = 255;
            255: if (req) begin nxt = 0; m_tflag = 0; end
            default: nxt = 0;
        endcase
        if (nxt == 255 && m_phase != 255) begin
            m_tflag = 1; m_pend = 0;
        end
        if (nxt != m_phase) begin
            m_enter = cyc;
            case (nxt)
                2: m_starts[0] = 1'b1;
                3: m_starts[1] = 1'b1;
                4: m_starts[2] = 1'b1;
                1: m_starts[3] = 1'b1;
                default: ;
            endcase
        end
        m_phase = nxt;
    endtask

    task automatic clear_inputs();
        bus.button_req  = 1'b0;
        bus.dht_done    = 1'b0;
        bus.dht_err     = 1'b0;
        bus.store_done  = 1'b0;
        bus.lcd_done    = 1'b0;
        bus.ws2812_done = 1'b0;
    endtask

    task automatic fire(int t);
        case (t)
            0: begin
                bus.dht_done = 1'b1;
                bus.dht_err = (err_mode == 2) ?
                    1'($urandom_range(0, 1)) : 1'(err_mode);
            end
            1: bus.store_done  = 1'b1;
            2: bus.lcd_done    = 1'b1;
            default: bus.ws2812_done = 1'b1;
        endcase
    endtask

    task automatic arm(int t);
        rtask = t;
        if (suppress[t]) rd = 0;
        else if (fixed_delay > 0) rd = fixed_delay;
        else if ($urandom_range(0, 14) == 0) rd = 0;
        else rd = $urandom_range(1, 8);
    endtask

    task automatic responder();
        if (auto_resp) begin
            if (bus.dht_start)    arm(0);
            if (bus.store_start)  arm(1);
            if (bus.lcd_start)    arm(2);
            if (bus.ws2812_start) arm(3);
            if (rd > 0) begin
                rd--;
                if (rd == 0) fire(rtask);
            end
        end
        if (rand_mode) begin
            if ($urandom_range(0, 29) == 0) bus.button_req = 1'b1;
            if ($urandom_range(0, 19) == 0) fire($urandom_range(0, 3));
        end
    endtask

    task automatic cyc_step();
        logic [3:0] st;
        @(posedge clk);
        model_step();
        #1;
        st = {bus.ws2812_start, bus.lcd_start,
              bus.store_start, bus.dht_start};
        chk("step", 32'(bus.project_step), 32'(m_phase));
        chk("starts", 32'(st), 32'(m_starts));
        chk("busy", 32'(bus.busy), 32'(ph_busy(m_phase)));
        chk("tflag", 32'(bus.timeout_flag), 32'(m_tflag));
        chk("ledr", 32'(bus.LEDR),
            32'({m_tflag, m_toggle, m_dhterr, ph_busy(m_phase)}));
        clear_inputs();
        responder();
    endtask

    task automatic wait_step(int v, int lim);
        int k;
        k = 0;
        while (int'(bus.project_step) != v && k < lim) begin
            cyc_step();
            k++;
        end
        chk("wait_step", 32'(bus.project_step), 32'(v));
    endtask

    task automatic check_reset_outputs(string tag);
        chk(tag, 32'({bus.project_step, bus.dht_start,
                      bus.store_start, bus.lcd_start,
                      bus.ws2812_start, bus.busy,
                      bus.timeout_flag, bus.LEDR}), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench stalled");
    end

    initial begin
        int first, nst, prev;
        int seq[$];
        int exp2[5];
        int t_lcd;
        exp2 = '{2, 3, 4, 1, 0};
        n_tests = 0;
        n_fail = 0;
        rst = 1'b0;
        clear_inputs();
        model_reset();
        auto_resp = 1;
        rand_mode = 0;
        fixed_delay = 5;
        err_mode = 0;
        suppress = '0;
        #7;
        check_reset_outputs("reset_initial");
        do_reset();

        first = -1;
        for (int i = 0; i < 40 && first < 0; i++) begin
            cyc_step();
            if (bus.dht_start) first = cyc;
        end
        chk("t1_first_dht", 32'(first), 32'd20);
        chk("t1_step", 32'(bus.project_step), 32'd2);
        chk("t1_busy", 32'(bus.busy), 32'd1);

        seq.push_back(2);
        nst = 1;
        prev = 2;
        for (int i = 0; i < 60 && prev != 0; i++) begin
            cyc_step();
            nst += int'(bus.dht_start) + int'(bus.store_start) +
                   int'(bus.lcd_start) + int'(bus.ws2812_start);
            if (int'(bus.project_step) != prev) begin
                prev = int'(bus.project_step);
                seq.push_back(prev);
            end
        end
        chk("t2_len", 32'(seq.size()), 32'd5);
        for (int i = 0; i < 5 && i < seq.size(); i++)
            chk("t2_seq", 32'(seq[i]), 32'(exp2[i]));
        chk("t2_starts", 32'(nst), 32'd4);
        chk("t2_toggle", 32'(bus.LEDR[2]), 32'd1);

        err_mode = 1;
        wait_step(2, 40);
        nst = 0;
        for (int i = 0; i < 60 && bus.project_step == 8'd2; i++) begin
            cyc_step();
            nst += int'(bus.store_start);
        end
        chk("t3_jump", 32'(bus.project_step), 32'd4);
        chk("t3_led1", 32'(bus.LEDR[1]), 32'd1);
        for (int i = 0; i < 60 && bus.project_step != 8'd0; i++) begin
            cyc_step();
            nst += int'(bus.store_start);
        end
        chk("t3_nostore", 32'(nst), 32'd0);

        err_mode = 0;
        suppress = 4'b0100;
        wait_step(4, 80);
        t_lcd = cyc;
        wait_step(255, 80);
        chk("t4_to_delay", 32'(cyc - t_lcd), 32'(TIMEOUT));
        chk("t4_flag", 32'(bus.timeout_flag), 32'd1);
        bus.button_req = 1'b1;
        cyc_step();
        chk("t4_clr_step", 32'(bus.project_step), 32'd0);
        chk("t4_clr_flag", 32'(bus.timeout_flag), 32'd0);

        suppress = '0;
        fixed_delay = 3;
        bus.button_req = 1'b1;
        wait_step(3, 20);
        bus.button_req = 1'b1;
        cyc_step();
        bus.button_req = 1'b1;
        cyc_step();
        wait_step(0, 40);
        cyc_step();
        chk("t5_restart", 32'(bus.dht_start), 32'd1);
        nst = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_step();
            nst += int'(bus.dht_start);
        end
        chk("t5_single", 32'(nst), 32'd0);

        wait_step(4, 60);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_async_rst");
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        fixed_delay = 5;
        wait_step(2, 40);
        bus.ws2812_done = 1'b1;
        cyc_step();
        chk("t6_stray", 32'(bus.project_step), 32'd2);

        fixed_delay = 0;
        err_mode = 2;
        rand_mode = 1;
        repeat (3000) cyc_step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
